// File: rtl/immext_pipe.sv
// Immediate extender feeding a 2-entry output FIFO with a valid/ready handshake
// on both sides and a wrapping count of completed output transfers.
module immext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    generate
        if (OUT_W < IN_W + 2 || CNT_W < 1) begin : g_bad_params
            $error("immext_pipe: need OUT_W >= IN_W+2 and CNT_W >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state, state_nxt;
    logic [OUT_W-1:0] e0, e1;
    logic [OUT_W-1:0] sext, ext;
    logic             accept, xfer;

    // Extension is formed combinationally from the live inputs and only
    // captured on an accepting edge, so idle-cycle inputs never matter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ext  = '0;
        sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
        case (in_mode)
            2'b00:   ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
            2'b01:   ext = sext;
            2'b10:   ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
            default: ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        accept    = in_valid && in_ready;
        xfer      = out_valid && out_ready;
        case (state)
            EMPTY:   if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !xfer)      state_nxt = FULL;
                else if (!accept && xfer) state_nxt = EMPTY;
            end
            FULL:    if (xfer) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the two entries are reset explicitly so out_data reads 0 during reset and stale data cannot leak out.
        if (!rst_n) begin
            e0 <= '0;
            e1 <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) e0 <= ext;
                ONE: begin
                    if (accept && xfer) e0 <= ext;
                    else if (accept)    e1 <= ext;
                end
                FULL:  if (xfer) e0 <= e1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    xfer_cnt <= '0;
        else if (xfer) xfer_cnt <= xfer_cnt + 1'b1;
    end

    assign out_data = e0;

endmodule

// File: tb/tb_immext_pipe.sv
// Directed bench for immext_pipe: mode table, backpressure, streaming,
// counter wrap, asynchronous reset mid-stream and a narrow parameter set.
module tb_immext_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [31:0] out_data;
    logic [7:0]  xfer_cnt;

    immext_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt)
    );

    // Narrow counter instance
    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [15:0] in_imm_w;
    logic [1:0]  in_mode_w;
    logic [31:0] out_data_w;
    logic [1:0]  xfer_cnt_w;

    immext_pipe #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_imm(in_imm_w), .in_mode(in_mode_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w), .xfer_cnt(xfer_cnt_w)
    );

    // Narrow data instance
    logic        in_valid_p, in_ready_p, out_valid_p, out_ready_p;
    logic [7:0]  in_imm_p;
    logic [1:0]  in_mode_p;
    logic [15:0] out_data_p;
    logic [7:0]  xfer_cnt_p;

    immext_pipe #(.IN_W(8), .OUT_W(16)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_p), .in_ready(in_ready_p), .in_imm(in_imm_p), .in_mode(in_mode_p),
        .out_valid(out_valid_p), .out_ready(out_ready_p), .out_data(out_data_p), .xfer_cnt(xfer_cnt_p)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];
    logic [1:0] wrap_exp[5];

    initial begin
        vecs[0] = '{"zero_8001",   2'b00, 16'h8001, 32'h0000_8001};
        vecs[1] = '{"sign_8001",   2'b01, 16'h8001, 32'hFFFF_8001};
        vecs[2] = '{"upper_8001",  2'b10, 16'h8001, 32'h8001_0000};
        vecs[3] = '{"branch_8001", 2'b11, 16'h8001, 32'hFFFE_0004};
        vecs[4] = '{"zero_7fff",   2'b00, 16'h7FFF, 32'h0000_7FFF};
        vecs[5] = '{"sign_7fff",   2'b01, 16'h7FFF, 32'h0000_7FFF};
        vecs[6] = '{"upper_7fff",  2'b10, 16'h7FFF, 32'h7FFF_0000};
        vecs[7] = '{"branch_7fff", 2'b11, 16'h7FFF, 32'h0001_FFFC};
        vecs[8] = '{"branch_ffff", 2'b11, 16'hFFFF, 32'hFFFF_FFFC};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_n = 1'b0;
        in_valid = 0; in_imm = '0; in_mode = '0; out_ready = 0;
        in_valid_w = 0; in_imm_w = '0; in_mode_w = '0; out_ready_w = 0;
        in_valid_p = 0; in_imm_p = '0; in_mode_p = '0; out_ready_p = 0;

        // Reset state held while rst_n is low, across clock edges
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
        rst_n = 1'b1;

        // Mode table: accept, then result visible one cycle later
        for (int i = 0; i < 9; i++) begin
            in_valid = 1; in_mode = vecs[i].mode; in_imm = vecs[i].imm; out_ready = 1;
            step();
            in_valid = 0; in_imm = 16'hDEAD; in_mode = 2'b10;
            check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            check(vecs[i].name, out_data, vecs[i].exp);
            step();
            check({vecs[i].name, "_drained"}, 32'(out_valid), 32'd0);
        end
        check("xfer_cnt_after_table", 32'(xfer_cnt), 32'd9);

        // Backpressure: three pushes against a stalled consumer
        rst_n = 1'b0; #1; rst_n = 1'b1;
        out_ready = 0; in_mode = 2'b00;
        in_valid = 1; in_imm = 16'h0001;
        step();
        check("bp_ready_after_1", 32'(in_ready), 32'd1);
        in_imm = 16'h0002;
        step();
        check("bp_ready_after_2", 32'(in_ready), 32'd0);
        check("bp_head_1", out_data, 32'h1);
        in_imm = 16'h0003;
        step();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_head_stable", out_data, 32'h1);
        out_ready = 1;
        step();
        check("bp_head_2", out_data, 32'h2);
        check("bp_ready_reopen", 32'(in_ready), 32'd1);
        step();
        in_valid = 0;
        check("bp_head_3", out_data, 32'h3);
        check("bp_valid_3", 32'(out_valid), 32'd1);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_xfer_cnt", 32'(xfer_cnt), 32'd3);

        // Streaming: one result per cycle after one cycle of latency
        rst_n = 1'b0; #1; rst_n = 1'b1;
        in_valid = 1; out_ready = 1; in_mode = 2'b00;
        for (int k = 1; k <= 100; k++) begin
            in_imm = 16'(k - 1);
            step();
            check($sformatf("stream_data_%0d", k - 1), out_data, 32'(k - 1));
            check($sformatf("stream_cnt_%0d", k - 1), 32'(xfer_cnt), 32'(k - 1));
        end
        in_valid = 0;
        step();
        check("stream_final_cnt", 32'(xfer_cnt), 32'd100);
        check("stream_empty", 32'(out_valid), 32'd0);

        // Reset mid-stream from FULL, asserted and released between edges
        out_ready = 0; in_valid = 1; in_imm = 16'hAAAA;
        step();
        in_imm = 16'hBBBB;
        step();
        in_valid = 0;
        check("mid_full", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
        check("mid_rst_out_data",  out_data,       32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1;
        step();
        check("mid_no_stale", 32'(out_valid), 32'd0);
        in_valid = 1; in_imm = 16'h1234;
        step();
        in_valid = 0;
        check("mid_first_accept_valid", 32'(out_valid), 32'd1);
        check("mid_first_accept_data", out_data, 32'h0000_1234);

        // Counter wrap with CNT_W=2
        in_valid_w = 1; out_ready_w = 1; in_mode_w = 2'b00; in_imm_w = 16'h0042;
        step();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) in_valid_w = 0;
            step();
            check($sformatf("wrap_cnt_%0d", k + 1), 32'(xfer_cnt_w), 32'(wrap_exp[k]));
        end

        // Narrow data path: IN_W=8, OUT_W=16
        out_ready_p = 1; in_valid_p = 1; in_mode_p = 2'b01; in_imm_p = 8'hF0;
        step();
        in_mode_p = 2'b11;
        check("p_sign_f0", 32'(out_data_p), 32'h0000_FFF0);
        step();
        in_valid_p = 0;
        check("p_branch_f0", 32'(out_data_p), 32'h0000_FFC0);
        step();
        check("p_drained", 32'(out_valid_p), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/immext_pipe.md
IMMEXT_PIPE -- requirements
Module: immext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width in bits.
REQ-002 Parameter OUT_W, default 32, extended output width in bits.
REQ-003 Parameter CNT_W, default 8, width of the transfer counter.
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  producer offers an immediate.
REQ-008 in_ready  output  1  block can accept an immediate this cycle.
REQ-009 in_imm  input  IN_W  immediate operand.
REQ-010 in_mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
REQ-011 out_valid  output  1  extended result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  OUT_W  extended result.
REQ-014 xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-015 Elaboration SHALL fail when OUT_W < IN_W+2 or CNT_W < 1.
REQ-016 Mode 00 SHALL produce in_imm zero-extended to OUT_W.
REQ-017 Mode 01 SHALL produce in_imm sign-extended to OUT_W by replicating in_imm[IN_W-1].
REQ-018 Mode 10 SHALL produce in_imm placed in bits [OUT_W-1:OUT_W-IN_W], with the lower bits zero.
REQ-019 Mode 11 SHALL produce in_imm sign-extended to OUT_W, then shifted left by 2, with the top 2 bits discarded and the low 2 bits zero.
REQ-020 Extension SHALL be computed at input acceptance, and the result SHALL be stored in a 2-entry FIFO (entries E0 = head, E1).
REQ-021 Input acceptance occurs when in_valid && in_ready on a rising edge.
REQ-022 Output transfer occurs when out_valid && out_ready on a rising edge.
REQ-023 Occupancy states: EMPTY (0), ONE (1), FULL (2). Transitions:
  - accept only: +1
  - transfer only: -1
  - both: unchanged
  - neither: unchanged
REQ-024 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; in_ready SHALL depend only on registered state.
REQ-025 out_valid SHALL be 1 in ONE and FULL; out_data SHALL equal E0 whenever out_valid is 1.
REQ-026 Latency: an immediate accepted in cycle N into EMPTY SHALL appear on out_data with out_valid=1 in cycle N+1.
REQ-027 Simultaneous accept and transfer in ONE SHALL replace E0 with the new result, leaving occupancy at ONE with no bubble.
REQ-028 A transfer in FULL SHALL move E1 into E0 in the same edge.
REQ-029 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 in_imm and in_mode SHALL be ignored when no acceptance occurs.
REQ-031 xfer_cnt SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-032 No data SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-033 While rst_n=0, the block SHALL hold: occupancy EMPTY, out_valid=0, in_ready=1, out_data=0, xfer_cnt=0, both FIFO entries 0.
REQ-034 Reset assertion mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.
REQ-035 After rst_n deasserts, the block SHALL accept input on the first rising edge.

Verification
REQ-036 Defaults, modes 00/01/10/11 with in_imm=16'h8001, out_ready=1 -> out_data = 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, each one cycle after acceptance.
REQ-037 Backpressure: out_ready=0, push 16'h0001, 16'h0002, 16'h0003 continuously -> in_ready=0 after the second accept; third value held off; release out_ready -> outputs 1, 2, 3 in order, none lost.
REQ-038 Streaming: in_valid=1 and out_ready=1 for 100 cycles -> one result per cycle after 1-cycle latency; xfer_cnt=100.
REQ-039 Wrap: CNT_W=2, 5 transfers -> xfer_cnt sequence 1, 2, 3, 0, 1.
REQ-040 Reset mid-stream: FULL, pulse rst_n low between edges -> out_valid=0, in_ready=1, xfer_cnt=0 immediately; stale data never appears afterward.
REQ-041 Parameter check: IN_W=8, OUT_W=16, mode 01, in_imm=8'hF0 -> out_data=16'hFFF0; mode 11 -> 16'hFFC0.
